// File: rtl/aha_wdog_multi_apb.sv
// NUM_CH-channel APB watchdog: interrupt on first expiry, sticky reset request on a second unserviced one.
// Define AHA_WDOG_WINDOW_EN to build the windowed-service check (CTRL[2], WINDOW, INTSTAT[31:16]).
module aha_wdog_multi_apb #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int ADDRWIDTH = 12
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic                 WDOGCLKEN,
  output logic [NUM_CH-1:0]    WDOG_INT,
  output logic                 WDOG_INT_OR,
  output logic                 WDOG_RESET
);
  localparam logic [31:0]          UNLOCK_KEY = 32'h1ACCE551;
  localparam logic [ADDRWIDTH-3:0] LOCK_WA    = 'h3C0;
  localparam logic [ADDRWIDTH-3:0] STAT_WA    = 'h3C1;

  logic [CNT_W-1:0] load_q [NUM_CH];
  logic [CNT_W-1:0] load_d [NUM_CH];
  logic [CNT_W-1:0] value_q [NUM_CH];
  logic [CNT_W-1:0] value_d [NUM_CH];
  logic [2:0]       ctrl_q [NUM_CH];
  logic [2:0]       ctrl_d [NUM_CH];
  logic [NUM_CH-1:0] int_q, int_d;
  logic locked_q, locked_d, wdog_reset_q, wdog_reset_d;
`ifdef AHA_WDOG_WINDOW_EN
  logic [CNT_W-1:0] window_q [NUM_CH];
  logic [CNT_W-1:0] window_d [NUM_CH];
  logic [NUM_CH-1:0] viol_q, viol_d;
`endif

  logic access, is_lock, is_stat, ch_ok, ro_reg, err, wr_ok, unused_addr;
  logic [ADDRWIDTH-6:0] ch_sel;
  logic [2:0]           reg_off;
  logic [NUM_CH-1:0]    wsel;
  logic [31:0]          stat;

  assign access      = PSEL & PENABLE;
  assign ch_sel      = PADDR[ADDRWIDTH-1:5];
  assign reg_off     = PADDR[4:2];
  assign unused_addr = ^PADDR[1:0];
  assign is_lock     = PADDR[ADDRWIDTH-1:2] == LOCK_WA;
  assign is_stat     = PADDR[ADDRWIDTH-1:2] == STAT_WA;
  assign ch_ok       = (int'(ch_sel) < NUM_CH) && (reg_off <= 3'd4);
  assign ro_reg      = is_stat | (ch_ok & (reg_off == 3'd1));
  assign err         = access & (~(is_lock | is_stat | ch_ok) |
                                 (PWRITE & (ro_reg | (locked_q & ~is_lock))));
  assign wr_ok       = access & PWRITE & ~err;
  assign PSLVERR     = err;
  assign PREADY      = 1'b1;
  assign WDOG_INT    = int_q;
  assign WDOG_INT_OR = |int_q;
  assign WDOG_RESET  = wdog_reset_q;

  always_comb begin
    wsel = '0;
    for (int c = 0; c < NUM_CH; c++) wsel[c] = wr_ok & ch_ok & (int'(ch_sel) == c);
    stat = '0;
    stat[NUM_CH-1:0] = int_q;
`ifdef AHA_WDOG_WINDOW_EN
    stat[16 +: NUM_CH] = viol_q;
`endif
  end

  always_comb begin
    PRDATA = '0;
    if (access) begin
      if (is_lock)      PRDATA = {31'b0, locked_q};
      else if (is_stat) PRDATA = stat;
      else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_ok && int'(ch_sel) == c) begin
            case (reg_off)
              3'd0:    PRDATA = 32'(load_q[c]);
              3'd1:    PRDATA = 32'(value_q[c]);
              3'd2:    PRDATA = {29'b0, ctrl_q[c]};
`ifdef AHA_WDOG_WINDOW_EN
              3'd4:    PRDATA = 32'(window_q[c]);
`endif
              default: PRDATA = '0;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    locked_d     = locked_q;
    wdog_reset_d = wdog_reset_q;
    if (wr_ok && is_lock) locked_d = (PWDATA != UNLOCK_KEY);
    for (int c = 0; c < NUM_CH; c++) begin
      load_d[c]  = load_q[c];
      value_d[c] = value_q[c];
      ctrl_d[c]  = ctrl_q[c];
      int_d[c]   = int_q[c];
`ifdef AHA_WDOG_WINDOW_EN
      window_d[c] = window_q[c];
      viol_d[c]   = viol_q[c];
`endif
      if (ctrl_q[c][0] && WDOGCLKEN) begin
        if (value_q[c] == '0) begin
          value_d[c] = load_q[c];
          int_d[c]   = 1'b1;
          // A service (INTCLR) landing on the expiry edge cancels the reset request.
          if (int_q[c] && ctrl_q[c][1] && !(wsel[c] && reg_off == 3'd3)) wdog_reset_d = 1'b1;
        end else begin
          value_d[c] = value_q[c] - CNT_W'(1);
        end
      end
      if (!ctrl_q[c][0]) int_d[c] = 1'b0;
      if (wsel[c]) begin
        case (reg_off)
          3'd0: begin
            load_d[c]  = PWDATA[CNT_W-1:0];
            value_d[c] = PWDATA[CNT_W-1:0];
          end
          3'd2: begin
`ifdef AHA_WDOG_WINDOW_EN
            ctrl_d[c] = PWDATA[2:0];
`else
            ctrl_d[c] = {1'b0, PWDATA[1:0]};
`endif
            if (!ctrl_q[c][0] && PWDATA[0]) value_d[c] = load_q[c];
          end
          3'd3: begin
            int_d[c]   = 1'b0;
            value_d[c] = load_q[c];
`ifdef AHA_WDOG_WINDOW_EN
            if (ctrl_q[c][2] && value_q[c] > window_q[c]) begin
              viol_d[c] = 1'b1;
              if (ctrl_q[c][1]) wdog_reset_d = 1'b1;
            end
`endif
          end
`ifdef AHA_WDOG_WINDOW_EN
          3'd4: window_d[c] = PWDATA[CNT_W-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      locked_q     <= 1'b0;
      wdog_reset_q <= 1'b0;
      int_q        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        load_q[c]  <= '1;
        value_q[c] <= '1;
        ctrl_q[c]  <= '0;
      end
`ifdef AHA_WDOG_WINDOW_EN
      viol_q <= '0;
      for (int c = 0; c < NUM_CH; c++) window_q[c] <= '0;
`endif
    end else begin
      locked_q     <= locked_d;
      wdog_reset_q <= wdog_reset_d;
      int_q        <= int_d;
      for (int c = 0; c < NUM_CH; c++) begin
        load_q[c]  <= load_d[c];
        value_q[c] <= value_d[c];
        ctrl_q[c]  <= ctrl_d[c];
      end
`ifdef AHA_WDOG_WINDOW_EN
      viol_q <= viol_d;
      for (int c = 0; c < NUM_CH; c++) window_q[c] <= window_d[c];
`endif
    end
  end
endmodule

// File: tb/tb_aha_wdog_multi_apb.sv
// Scoreboard bench for aha_wdog_multi_apb: read expectations queued at issue, compared at the access phase.
module tb_aha_wdog_multi_apb;
  logic clk = 1'b0, rst = 1'b1;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0, clken = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic pready, pslverr, int_or, wreset;
  logic [3:0] wint;
  int n_chk = 0, n_fail = 0;

  typedef struct { string tag; logic [31:0] exp; logic err; } exp_t;
  exp_t sb_q[$];
  logic [31:0] rdv;
  logic        errv;

  always #5 clk = ~clk;

  aha_wdog_multi_apb #(.NUM_CH(4), .CNT_W(32), .ADDRWIDTH(12)) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .WDOGCLKEN(clken), .WDOG_INT(wint), .WDOG_INT_OR(int_or), .WDOG_RESET(wreset));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // tk holds WDOGCLKEN high on the commit edge so a write can race a counter tick.
  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d, input bit tk,
                     output logic [31:0] rd, output logic er);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; clken = tk;
    @(negedge clk);
    rd = prdata; er = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; clken = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_err,
                    input string tag, input bit tk = 1'b0);
    apb(1'b1, a, d, tk, rdv, errv);
    chk({tag, ".err"}, {31'b0, errv}, {31'b0, exp_err});
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic exp_err, input string tag);
    exp_t e;
    sb_q.push_back('{tag: tag, exp: exp, err: exp_err});
    apb(1'b0, a, 32'h0, 1'b0, rdv, errv);
    e = sb_q.pop_front();
    chk(e.tag, rdv, e.exp);
    chk({e.tag, ".err"}, {31'b0, errv}, {31'b0, e.err});
  endtask

  task automatic tick(input int n);
    @(posedge clk); #1; clken = 1'b1;
    repeat (n) @(posedge clk);
    #1; clken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; psel = 1'b0; penable = 1'b0; clken = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    // Reset state.
    chk("rst.int", {28'b0, wint}, 32'h0);
    chk("rst.reset", {31'b0, wreset}, 32'h0);
    chk("rst.prdata_idle", prdata, 32'h0);
    rd(12'h000, 32'hFFFF_FFFF, 1'b0, "rst.load");
    rd(12'h004, 32'hFFFF_FFFF, 1'b0, "rst.value");
    rd(12'h008, 32'h0, 1'b0, "rst.ctrl");
    rd(12'hF00, 32'h0, 1'b0, "rst.lock");

    // Basic expiry.
    wr(12'h000, 32'd5, 1'b0, "t1.load");
    wr(12'h008, 32'd1, 1'b0, "t1.ctrl");
    tick(5);
    chk("t1.int_pre", {28'b0, wint}, 32'h0);
    rd(12'h004, 32'd0, 1'b0, "t1.value0");
    tick(1);
    chk("t1.int", {28'b0, wint}, 32'h1);
    chk("t1.int_or", {31'b0, int_or}, 32'h1);
    rd(12'h004, 32'd5, 1'b0, "t1.reload");
    rd(12'hF04, 32'h1, 1'b0, "t1.stat");

    // Second unserviced expiry.
    do_reset();
    wr(12'h000, 32'd5, 1'b0, "t2.load");
    wr(12'h008, 32'd3, 1'b0, "t2.ctrl");
    tick(11);
    chk("t2.reset_pre", {31'b0, wreset}, 32'h0);
    tick(1);
    chk("t2.reset", {31'b0, wreset}, 32'h1);
    wr(12'h00C, 32'h0, 1'b0, "t2.clr");
    wr(12'h008, 32'h0, 1'b0, "t2.off");
    tick(3);
    chk("t2.sticky", {31'b0, wreset}, 32'h1);
    do_reset();
    chk("t2.reset_cleared", {31'b0, wreset}, 32'h0);

    // INTCLR on the expiry edge with int already pending.
    wr(12'h000, 32'd5, 1'b0, "t3.load");
    wr(12'h008, 32'd3, 1'b0, "t3.ctrl");
    tick(6);
    chk("t3.int_first", {28'b0, wint}, 32'h1);
    tick(5);
    wr(12'h00C, 32'h0, 1'b0, "t3.clr_race", 1'b1);
    chk("t3.int", {28'b0, wint}, 32'h0);
    chk("t3.reset", {31'b0, wreset}, 32'h0);
    rd(12'h004, 32'd5, 1'b0, "t3.value");

    // LOAD write on the expiry edge: new load taken, int still set.
    do_reset();
    wr(12'h000, 32'd5, 1'b0, "t3b.load");
    wr(12'h008, 32'd1, 1'b0, "t3b.ctrl");
    tick(5);
    wr(12'h000, 32'd7, 1'b0, "t3b.load_race", 1'b1);
    chk("t3b.int", {28'b0, wint}, 32'h1);
    rd(12'h004, 32'd7, 1'b0, "t3b.value");

    // LOAD=0: expiry every tick, reset on the second.
    do_reset();
    wr(12'h000, 32'd0, 1'b0, "t3c.load");
    wr(12'h008, 32'd3, 1'b0, "t3c.ctrl");
    tick(1);
    chk("t3c.int", {28'b0, wint}, 32'h1);
    chk("t3c.reset_pre", {31'b0, wreset}, 32'h0);
    tick(1);
    chk("t3c.reset", {31'b0, wreset}, 32'h1);

    // Lock.
    do_reset();
    wr(12'hF00, 32'h0, 1'b0, "t4.lock");
    rd(12'hF00, 32'h1, 1'b0, "t4.locked");
    wr(12'h000, 32'd9, 1'b1, "t4.load_locked");
    rd(12'h000, 32'hFFFF_FFFF, 1'b0, "t4.load_kept");
    wr(12'hF00, 32'h1ACC_E551, 1'b0, "t4.unlock");
    rd(12'hF00, 32'h0, 1'b0, "t4.unlocked");
    wr(12'h000, 32'd9, 1'b0, "t4.load");
    rd(12'h004, 32'd9, 1'b0, "t4.value");

    // Channel isolation and address errors.
    do_reset();
    wr(12'h020, 32'd7, 1'b0, "t5.ch1_load");
    wr(12'h040, 32'd3, 1'b0, "t5.ch2_load");
    wr(12'h048, 32'd1, 1'b0, "t5.ch2_ctrl");
    tick(4);
    rd(12'hF04, 32'h4, 1'b0, "t5.stat");
    chk("t5.int_or", {31'b0, int_or}, 32'h1);
    rd(12'h024, 32'd7, 1'b0, "t5.ch1_frozen");
    rd(12'h080, 32'h0, 1'b1, "t5.ch4_rd");
    wr(12'h080, 32'h1, 1'b1, "t5.ch4_wr");
    wr(12'h024, 32'h1, 1'b1, "t5.value_ro");
    wr(12'hF04, 32'h1, 1'b1, "t5.stat_ro");
    rd(12'h014, 32'h0, 1'b1, "t5.unmapped");

    // Window mode.
    do_reset();
    wr(12'h010, 32'd10, 1'b0, "t6.window");
    wr(12'h000, 32'd100, 1'b0, "t6.load");
    wr(12'h008, 32'd7, 1'b0, "t6.ctrl");
    tick(50);
    rd(12'h004, 32'd50, 1'b0, "t6.value50");
    wr(12'h00C, 32'h0, 1'b0, "t6.clr");
    rd(12'h004, 32'd100, 1'b0, "t6.reload");
`ifdef AHA_WDOG_WINDOW_EN
    rd(12'hF04, 32'h0001_0000, 1'b0, "t6.stat");
    chk("t6.reset", {31'b0, wreset}, 32'h1);
    rd(12'h010, 32'd10, 1'b0, "t6.window_rd");
    rd(12'h008, 32'd7, 1'b0, "t6.ctrl_rd");
`else
    rd(12'hF04, 32'h0, 1'b0, "t6.stat");
    chk("t6.reset", {31'b0, wreset}, 32'h0);
    rd(12'h010, 32'd0, 1'b0, "t6.window_rd");
    rd(12'h008, 32'd3, 1'b0, "t6.ctrl_rd");
`endif

    chk("sb.empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
